sdram_pattern_tester: RTL and testbench
=======================================

SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 26, byte-address width; DATA_W, default 64, data width (multiple of 8, max 64); CNT_W, default 16, operation-count width; TIMEOUT, default 1024, max cycles per memory handshake phase.
REQ-002 Ports SHALL be (name direction width meaning):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse that begins a test run; sampled only in IDLE.
- base_address  in  ADDR_W  first byte address.
- op_size  in  2  access size, 2^op_size bytes.
- op_count  in  CNT_W  number of accesses per phase.
- seed  in  64  LFSR seed.
- mem_address  out  ADDR_W  controller address.
- mem_rd_en  out  1  read request pulse.
- mem_wr_en  out  1  write request pulse.
- mem_size  out  2  controller access size.
- mem_write_data  out  DATA_W  write data.
- mem_read_data  in  DATA_W  controller read data.
- mem_busy  in  1  controller busy.
- running  out  1  test in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  valid while done: no mismatch and no timeout.
- timeout  out  1  handshake timeout occurred.
- error_count  out  CNT_W  mismatches, saturating.
- first_err_addr  out  ADDR_W  address of first mismatch.

Function
REQ-003 FSM states SHALL be IDLE, WR_REQ, WR_BUSY, WR_DONE, RD_REQ, RD_BUSY, RD_DONE, CHECK, FINISH.
REQ-004 In IDLE or FINISH, start=1 SHALL latch base_address with its low op_size bits cleared, op_size, op_count, and seed (seed 0 is replaced by 1); it SHALL clear error_count, timeout, done, pass, and first_err_addr, and SHALL enter WR_REQ the next cycle.
REQ-005 op_count=0 SHALL go directly to FINISH with pass=1 and no memory requests.
REQ-006 WR_REQ SHALL wait for mem_busy=0, then drive mem_wr_en=1 for exactly one cycle with mem_write_data set to the low DATA_W bits of the current LFSR value, and SHALL enter WR_BUSY.
REQ-007 WR_BUSY SHALL wait for mem_busy=1, then WR_DONE SHALL wait for mem_busy=0; the access is then complete.
REQ-008 On write completion, the LFSR SHALL advance one step, using Fibonacci taps 64,63,61,60 with a left shift and the feedback bit entering at bit 0. The address SHALL increase by 2^op_size modulo 2^ADDR_W. After op_count writes, the FSM SHALL reload address and LFSR from the latched values and enter RD_REQ; otherwise it SHALL return to WR_REQ.
REQ-009 The read phase SHALL mirror the write phase using mem_rd_en, RD_BUSY, and RD_DONE. On mem_busy falling, mem_read_data SHALL be registered and the FSM SHALL enter CHECK.
REQ-010 CHECK SHALL compare only the low 8*2^op_size bits of the registered read data against the LFSR value; upper bits are ignored.
REQ-011 On a mismatch, error_count SHALL increment and saturate at 2^CNT_W-1, and first_err_addr SHALL be captured only on the first mismatch.
REQ-012 After CHECK, the LFSR and address SHALL advance as in REQ-008; after op_count reads the FSM SHALL enter FINISH, otherwise RD_REQ.
REQ-013 mem_rd_en and mem_wr_en SHALL never both be 1, and each SHALL be high for at most one cycle per access.
REQ-014 A watchdog SHALL count the cycles spent in any *_REQ, *_BUSY, or *_DONE state and SHALL reset on every state change. On reaching TIMEOUT it SHALL set timeout=1 and go to FINISH.
REQ-015 In FINISH: done=1, pass=(error_count==0 && !timeout), running=0. Everywhere else except IDLE: running=1 and done=0.
REQ-016 start asserted while running SHALL be ignored.
REQ-017 mem_size SHALL equal the latched op_size at all times; mem_address SHALL show the current access address from request until completion.

Reset
REQ-018 Assertion of reset SHALL immediately force IDLE. All outputs SHALL go to 0, as SHALL the LFSR, the counters, and the watchdog. This applies mid-operation, and no further request pulses SHALL follow.
REQ-019 After reset is released, the block SHALL stay in IDLE until start.

Verification
REQ-020 Controller model: 3-cycle busy and a byte-accurate 128-entry memory. Stimulus: base 0x0000010, size 3, count 8, seed 0x0123456789ABCDEF. Required response: 8 writes, then 8 reads at addresses 0x10 to 0x48 in steps of 8, and done=1, pass=1, error_count=0.
REQ-021 Stimulus: same run with the model corrupting bit 0 of the 3rd read. Required response: error_count=1, first_err_addr=0x20, pass=0.
REQ-022 Stimulus: size 0, base 0x3FFFFFF, count 2, seed 0. Required response: seed replaced by 1, addresses 0x3FFFFFF then 0x0000000 (wrap), and comparison on bits [7:0] only.
REQ-023 Stimulus: model never raises busy, TIMEOUT=16. Required response: timeout=1, done=1, pass=0, and exactly one mem_wr_en pulse.
REQ-024 Stimulus: reset asserted during RD_BUSY, then start re-issued with count 0. Required response: all outputs 0 while reset is high; after the new start, done=1 and pass=1 with no memory requests.

Source files
------------

// File: rtl/sdram_pattern_tester_if.sv
// Memory-controller request bus between the pattern tester and an SDRAM controller.
// The tester is the master; the controller answers with busy and read data.
interface sdram_pattern_tester_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_busy;

    modport master (
        output mem_address, mem_rd_en, mem_wr_en,
        output mem_size, mem_write_data,
        input  mem_read_data, mem_busy
    );

    modport slave (
        input  mem_address, mem_rd_en, mem_wr_en,
        input  mem_size, mem_write_data,
        output mem_read_data, mem_busy
    );
endinterface

// File: rtl/sdram_pattern_tester.sv
// Writes an LFSR pattern over a memory region, reads it back and checks it,
// with a per-handshake watchdog and a saturating mismatch counter.
module sdram_pattern_tester #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [1:0]        op_size,
    input  logic [CNT_W-1:0]  op_count,
    input  logic [63:0]       seed,
    sdram_pattern_tester_if.master mem,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  error_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, WR_REQ, WR_BUSY, WR_DONE,
        RD_REQ, RD_BUSY, RD_DONE, CHECK, FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr, base_l, addr_next, aligned;
    logic [63:0]       lfsr, seed_l, lfsr_next, m64;
    logic [1:0]        size_l;
    logic [CNT_W-1:0]  count_l, idx;
    logic [WD_W-1:0]   wdog;
    logic [DATA_W-1:0] rdata, cmp_mask;
    logic              mismatch, waiting, advance, last, wd_expire;

    assign mem.mem_address = addr;
    assign mem.mem_size    = size_l;

    assign lfsr_next = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    assign addr_next = addr + (ADDR_W'(1) << size_l);
    assign aligned   = base_address & ({ADDR_W{1'b1}} << op_size);
    assign last      = (idx == count_l - CNT_W'(1));

    always_comb begin
        m64 = '1;
        case (size_l)
            2'd0:    m64 = 64'h0000_0000_0000_00FF;
            2'd1:    m64 = 64'h0000_0000_0000_FFFF;
            2'd2:    m64 = 64'h0000_0000_FFFF_FFFF;
            default: m64 = '1;
        endcase
        cmp_mask = m64[DATA_W-1:0];
    end

    assign mismatch = |((rdata ^ lfsr[DATA_W-1:0]) & cmp_mask);

    // advance: the condition that moves a handshake state forward this cycle
    always_comb begin
        waiting = 1'b0;
        advance = 1'b0;
        case (state)
            WR_REQ, RD_REQ, WR_DONE, RD_DONE: begin
                waiting = 1'b1;
                advance = !mem.mem_busy;
            end
            WR_BUSY, RD_BUSY: begin
                waiting = 1'b1;
                advance = mem.mem_busy;
            end
            default: ;
        endcase
    end

    assign wd_expire = waiting && !advance && (wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            addr               <= '0;
            base_l             <= '0;
            lfsr               <= '0;
            seed_l             <= '0;
            size_l             <= '0;
            count_l            <= '0;
            idx                <= '0;
            wdog               <= '0;
            rdata              <= '0;
            mem.mem_rd_en      <= 1'b0;
            mem.mem_wr_en      <= 1'b0;
            mem.mem_write_data <= '0;
            running            <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            timeout            <= 1'b0;
            error_count        <= '0;
            first_err_addr     <= '0;
        end else begin
            mem.mem_wr_en <= 1'b0;
            mem.mem_rd_en <= 1'b0;
            if (waiting && !advance) wdog <= wdog + 1'b1;
            else                     wdog <= '0;

            case (state)
                IDLE, FINISH: if (start) begin
                    base_l         <= aligned;
                    addr           <= aligned;
                    size_l         <= op_size;
                    count_l        <= op_count;
                    idx            <= '0;
                    seed_l         <= (seed == 64'd0) ? 64'd1 : seed;
                    lfsr           <= (seed == 64'd0) ? 64'd1 : seed;
                    error_count    <= '0;
                    timeout        <= 1'b0;
                    first_err_addr <= '0;
                    if (op_count == '0) begin
                        state   <= FINISH;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                        running <= 1'b0;
                    end else begin
                        state   <= WR_REQ;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        running <= 1'b1;
                    end
                end
                WR_REQ: if (!mem.mem_busy) begin
                    mem.mem_wr_en      <= 1'b1;
                    mem.mem_write_data <= lfsr[DATA_W-1:0];
                    state              <= WR_BUSY;
                end
                WR_BUSY: if (mem.mem_busy) state <= WR_DONE;
                WR_DONE: if (!mem.mem_busy) begin
                    idx <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        addr  <= base_l;
                        lfsr  <= seed_l;
                        state <= RD_REQ;
                    end else begin
                        addr  <= addr_next;
                        lfsr  <= lfsr_next;
                        state <= WR_REQ;
                    end
                end
                RD_REQ: if (!mem.mem_busy) begin
                    mem.mem_rd_en <= 1'b1;
                    state         <= RD_BUSY;
                end
                RD_BUSY: if (mem.mem_busy) state <= RD_DONE;
                RD_DONE: if (!mem.mem_busy) begin
                    rdata <= mem.mem_read_data;
                    state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (error_count == '0) first_err_addr <= addr;
                        if (error_count != '1) error_count <= error_count + 1'b1;
                    end
                    addr <= addr_next;
                    lfsr <= lfsr_next;
                    idx  <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        state   <= FINISH;
                        done    <= 1'b1;
                        running <= 1'b0;
                        pass    <= (error_count == '0) && !mismatch && !timeout;
                    end else begin
                        state <= RD_REQ;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wd_expire) begin
                timeout <= 1'b1;
                state   <= FINISH;
                done    <= 1'b1;
                running <= 1'b0;
                pass    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench: 3-cycle-busy byte memory model, request monitor,
// and one task per scenario with hand-computed expectations.
module tb_sdram_pattern_tester;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [25:0] base_address = '0;
    logic [1:0]  op_size = '0;
    logic [15:0] op_count = '0;
    logic [63:0] seed = '0;
    logic        running, done, pass, timeout;
    logic [15:0] error_count;
    logic [25:0] first_err_addr;

    int vectors = 0;
    int miscompares = 0;

    sdram_pattern_tester_if #(.ADDR_W(26), .DATA_W(64)) mem ();

    sdram_pattern_tester #(
        .ADDR_W(26), .DATA_W(64), .CNT_W(16), .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .base_address(base_address), .op_size(op_size),
        .op_count(op_count), .seed(seed), .mem(mem.master),
        .running(running), .done(done), .pass(pass),
        .timeout(timeout), .error_count(error_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clock = ~clock;

    // controller model
    logic [7:0]  mem_arr [128];
    logic [2:0]  bcnt;
    logic [6:0]  rd_addr;
    logic        corrupt_now;
    logic [63:0] rdw;
    int          rd_seen;
    int          corrupt_at = -1;
    logic        no_busy = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            mem.mem_busy <= 1'b0;
            bcnt         <= '0;
            rd_addr      <= '0;
            corrupt_now  <= 1'b0;
            rd_seen      <= 0;
            for (int i = 0; i < 128; i++) mem_arr[i] <= 8'hA5 ^ 8'(i);
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1'b1;
            if (bcnt == 3'd1) mem.mem_busy <= 1'b0;
        end else if (mem.mem_wr_en) begin
            if (!no_busy) begin
                mem.mem_busy <= 1'b1;
                bcnt         <= 3'd3;
            end
            for (int i = 0; i < 8; i++)
                if (i < (1 << mem.mem_size))
                    mem_arr[7'(mem.mem_address + 26'(i))] <= mem.mem_write_data[8*i +: 8];
        end else if (mem.mem_rd_en) begin
            if (!no_busy) begin
                mem.mem_busy <= 1'b1;
                bcnt         <= 3'd3;
            end
            rd_addr     <= mem.mem_address[6:0];
            rd_seen     <= rd_seen + 1;
            corrupt_now <= (rd_seen + 1 == corrupt_at);
        end
    end

    always_comb begin
        rdw = '0;
        for (int i = 0; i < 8; i++) rdw[8*i +: 8] = mem_arr[7'(rd_addr + 7'(i))];
        mem.mem_read_data = rdw ^ {63'd0, corrupt_now};
    end

    // request monitor
    logic [25:0] wa [64];
    logic [63:0] wd [64];
    logic [25:0] ra [64];
    int   wr_n = 0;
    int   rd_n = 0;
    int   viol = 0;
    logic pw = 1'b0;
    logic pr = 1'b0;

    always @(negedge clock) begin
        if (mem.mem_wr_en) begin
            wa[wr_n[5:0]] <= mem.mem_address;
            wd[wr_n[5:0]] <= mem.mem_write_data;
            wr_n <= wr_n + 1;
        end
        if (mem.mem_rd_en) begin
            ra[rd_n[5:0]] <= mem.mem_address;
            rd_n <= rd_n + 1;
        end
        if ((mem.mem_wr_en && mem.mem_rd_en) || (mem.mem_wr_en && pw) ||
            (mem.mem_rd_en && pr))
            viol <= viol + 1;
        pw <= mem.mem_wr_en;
        pr <= mem.mem_rd_en;
    end

    logic [139:0] zv;
    assign zv = {running, done, pass, timeout, error_count, first_err_addr,
                 mem.mem_address, mem.mem_size, mem.mem_rd_en, mem.mem_wr_en,
                 mem.mem_write_data};

    function automatic logic [63:0] lfsr_step(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    endfunction

    task automatic kick(input logic [25:0] b, input logic [1:0] s,
                        input logic [15:0] c, input logic [63:0] sd);
        @(negedge clock);
        base_address = b;
        op_size = s;
        op_count = c;
        seed = sd;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clock);
            #1;
            n++;
        end
        vectors++;
        if (!done) begin
            $display("FAIL %s done_wait: done=%0b after %0d cycles, required 1", tag, done, n);
            miscompares++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if (zv !== '0) begin
            $display("FAIL reset_outputs: got %h, required 0", zv);
            miscompares++;
        end
        reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        vectors++;
        if ({running, done, wr_n != 0, rd_n != 0} !== 4'b0) begin
            $display("FAIL idle_hold: running=%0b done=%0b wr=%0d rd=%0d, required all 0",
                     running, done, wr_n, rd_n);
            miscompares++;
        end
    endtask

    task automatic test_basic;
        int wb = wr_n;
        int rb = rd_n;
        logic [63:0] exp = 64'h0123456789ABCDEF;
        kick(26'h0000010, 2'd3, 16'd8, 64'h0123456789ABCDEF);
        repeat (10) @(negedge clock);
        vectors++;
        if (running !== 1'b1) begin
            $display("FAIL basic_running: got %0b, required 1", running);
            miscompares++;
        end
        kick(26'h0000040, 2'd0, 16'd2, 64'h5);
        wait_done("basic");
        vectors++;
        if ({wr_n - wb, rd_n - rb} !== {32'd8, 32'd8}) begin
            $display("FAIL basic_counts: wr=%0d rd=%0d, required 8 8", wr_n - wb, rd_n - rb);
            miscompares++;
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (wa[wb+i] !== 26'h10 + 26'(8*i) || ra[rb+i] !== 26'h10 + 26'(8*i)) begin
                $display("FAIL basic_addr[%0d]: wr=%h rd=%h, required %h",
                         i, wa[wb+i], ra[rb+i], 26'h10 + 26'(8*i));
                miscompares++;
            end
            vectors++;
            if (wd[wb+i] !== exp) begin
                $display("FAIL basic_wdata[%0d]: got %h, required %h", i, wd[wb+i], exp);
                miscompares++;
            end
            exp = lfsr_step(exp);
        end
        vectors++;
        if (wd[wb+1] !== 64'h02468ACF13579BDE) begin
            $display("FAIL basic_wdata_step1: got %h, required 02468acf13579bde", wd[wb+1]);
            miscompares++;
        end
        vectors++;
        if ({done, pass, running, timeout, error_count, mem.mem_size} !== {4'b1100, 16'd0, 2'd3}) begin
            $display("FAIL basic_status: done=%0b pass=%0b run=%0b to=%0b err=%0d size=%0d, required 1 1 0 0 0 3",
                     done, pass, running, timeout, error_count, mem.mem_size);
            miscompares++;
        end
    endtask

    task automatic test_mismatch;
        corrupt_at = rd_seen + 3;
        kick(26'h0000010, 2'd3, 16'd8, 64'h0123456789ABCDEF);
        wait_done("mismatch");
        corrupt_at = -1;
        vectors++;
        if ({error_count, first_err_addr, pass, done} !== {16'd1, 26'h20, 2'b01}) begin
            $display("FAIL mismatch_status: err=%0d first=%h pass=%0b done=%0b, required 1 20 0 1",
                     error_count, first_err_addr, pass, done);
            miscompares++;
        end
    endtask

    task automatic test_wrap;
        int wb = wr_n;
        int rb = rd_n;
        kick(26'h3FFFFFF, 2'd0, 16'd2, 64'd0);
        wait_done("wrap");
        vectors++;
        if ({wa[wb], wa[wb+1], ra[rb], ra[rb+1]} !== {26'h3FFFFFF, 26'h0, 26'h3FFFFFF, 26'h0}) begin
            $display("FAIL wrap_addr: wr %h %h rd %h %h, required 3ffffff 0000000",
                     wa[wb], wa[wb+1], ra[rb], ra[rb+1]);
            miscompares++;
        end
        vectors++;
        if ({wd[wb], wd[wb+1]} !== {64'd1, 64'd2}) begin
            $display("FAIL wrap_wdata: got %h %h, required 1 2", wd[wb], wd[wb+1]);
            miscompares++;
        end
        vectors++;
        if ({wr_n - wb, rd_n - rb, pass, error_count} !== {32'd2, 32'd2, 1'b1, 16'd0}) begin
            $display("FAIL wrap_status: wr=%0d rd=%0d pass=%0b err=%0d, required 2 2 1 0",
                     wr_n - wb, rd_n - rb, pass, error_count);
            miscompares++;
        end
    endtask

    task automatic test_timeout;
        int wb = wr_n;
        int rb = rd_n;
        no_busy = 1'b1;
        kick(26'h0000013, 2'd2, 16'd4, 64'h55);
        wait_done("timeout");
        no_busy = 1'b0;
        vectors++;
        if ({timeout, done, pass} !== 3'b110) begin
            $display("FAIL timeout_status: to=%0b done=%0b pass=%0b, required 1 1 0",
                     timeout, done, pass);
            miscompares++;
        end
        vectors++;
        if ({wr_n - wb, rd_n - rb} !== {32'd1, 32'd0}) begin
            $display("FAIL timeout_pulses: wr=%0d rd=%0d, required 1 0", wr_n - wb, rd_n - rb);
            miscompares++;
        end
        vectors++;
        if ({wa[wb], wd[wb]} !== {26'h10, 64'h55}) begin
            $display("FAIL timeout_align: addr=%h data=%h, required 10 55", wa[wb], wd[wb]);
            miscompares++;
        end
    endtask

    task automatic test_reset_midrun;
        int rb = rd_n;
        int wb;
        int n = 0;
        kick(26'h0000010, 2'd3, 16'd8, 64'h0123456789ABCDEF);
        while (rd_n == rb && n < 2000) begin
            @(negedge clock);
            #1;
            n++;
        end
        vectors++;
        if (rd_n == rb) begin
            $display("FAIL midrun_read_wait: no read after %0d cycles, required one", n);
            miscompares++;
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if (zv !== '0) begin
            $display("FAIL midrun_reset_outputs: got %h, required 0", zv);
            miscompares++;
        end
        wb = wr_n;
        rb = rd_n;
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if ({zv != '0, wr_n - wb, rd_n - rb} !== {1'b0, 32'd0, 32'd0}) begin
            $display("FAIL midrun_reset_hold: out=%h wr=%0d rd=%0d, required 0 0 0",
                     zv, wr_n - wb, rd_n - rb);
            miscompares++;
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        kick(26'h0000010, 2'd3, 16'd0, 64'h1);
        wait_done("zero_count");
        repeat (4) @(negedge clock);
        #1;
        vectors++;
        if ({done, pass, running, wr_n - wb, rd_n - rb} !== {3'b110, 32'd0, 32'd0}) begin
            $display("FAIL zero_count: done=%0b pass=%0b run=%0b wr=%0d rd=%0d, required 1 1 0 0 0",
                     done, pass, running, wr_n - wb, rd_n - rb);
            miscompares++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_mismatch;
        test_wrap;
        test_timeout;
        test_reset_midrun;
        vectors++;
        if (viol !== 0) begin
            $display("FAIL pulse_rules: %0d violations, required 0", viol);
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
